// File: rtl/branch_predictor.sv
// Gshare branch predictor: a PHT of 2-bit saturating counters indexed by PC xor a
// non-speculative global history register, plus resolved/mispredicted branch counters.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         pc_out,
  input  logic [3:0]          pc_opcode,
  output logic                prediction,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                update_en,
  input  logic [3:0]          idex_opcode,
  input  logic [IDX_BITS-1:0] idex_pred_idx,
  input  logic                idex_prediction,
  input  logic                br_en,
  output logic [15:0]         br_count,
  output logic [15:0]         mispredict_count
);

  localparam int          PHT_DEPTH = 1 << IDX_BITS;
  localparam logic [3:0]  OP_BR     = 4'b0000;
  localparam logic [1:0]  CTR_INIT  = 2'b01;

  logic [1:0]          pht [PHT_DEPTH];
  logic [IDX_BITS-1:0] ghr;
  logic                resolve;
  logic [1:0]          ctr_cur;
  logic [1:0]          ctr_next;

  // Only the index slice of the PC feeds the hash; bit 0 is always zero for aligned fetches.
  logic unused_pc;
  assign unused_pc = ^{pc_out[15:IDX_BITS+1], pc_out[0]};

  assign pred_idx   = pc_out[IDX_BITS:1] ^ ghr;
  assign prediction = (pc_opcode == OP_BR) && pht[pred_idx][1];

  assign resolve = update_en && (idex_opcode == OP_BR);
  assign ctr_cur = pht[idex_pred_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (br_en) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= CTR_INIT;
      ghr              <= '0;
      br_count         <= '0;
      mispredict_count <= '0;
    end else if (resolve) begin
      pht[idex_pred_idx] <= ctr_next;
      ghr                <= {ghr[IDX_BITS-2:0], br_en};
      if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if ((idex_prediction != br_en) && (mispredict_count != 16'hFFFF))
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule
